// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel mux with direct select or one-shot auto-scan over all enabled channels.
// Optional channel mask when MUX_SCAN_MASK_EN is defined; output is a valid/ready register, latency 1.
module mux_scan_nx1 #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          s,
  input  logic                      mode,
  input  logic                      start,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          o,
  output logic [SEL_W-1:0]          o_ch,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic                      busy
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ch_q;
  logic [DW_W-1:0]   dwell_q;
  logic [CHANNELS-1:0] en;
  logic              free, expired, any_en;
  logic              found, more;
  logic [SEL_W-1:0]  tgt;
  logic [WIDTH-1:0]  dir_dat, scan_dat;
  logic              load, scan_load, scan_go;
  logic [WIDTH-1:0]  load_dat;
  logic [SEL_W-1:0]  load_ch;

`ifdef MUX_SCAN_MASK_EN
  assign en = mask;
`else
  assign en = '1;
`endif

  assign free    = !o_valid || o_ready;
  assign expired = (dwell_q == DW_MAX);
  assign any_en  = |en;

  // Lowest enabled channel at or above ch_q, and whether another one follows it.
  always_comb begin
    found    = 1'b0;
    more     = 1'b0;
    tgt      = '0;
    scan_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (en[k] && k >= int'(ch_q)) begin
        if (found) begin
          more = 1'b1;
        end else begin
          found    = 1'b1;
          tgt      = SEL_W'(k);
          scan_dat = d[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Out-of-range or masked selects read as zero.
  always_comb begin
    dir_dat = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(s) == k && en[k]) dir_dat = d[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (mode && start && any_en) state_d = SCAN;
      SCAN:  if (!found || (free && expired && !more)) state_d = DRAIN;
      DRAIN: if (free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    scan_go   = (state_q == IDLE) && mode && start && any_en;
    scan_load = (state_q == SCAN) && found && free && expired;
    load      = 1'b0;
    load_dat  = '0;
    load_ch   = '0;
    if (state_q == IDLE && !mode && free) begin
      load     = 1'b1;
      load_dat = dir_dat;
      load_ch  = s;
    end else if (scan_load) begin
      load     = 1'b1;
      load_dat = scan_dat;
      load_ch  = tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o       <= '0;
      o_ch    <= '0;
      o_valid <= 1'b0;
      ch_q    <= '0;
      dwell_q <= '0;
    end else begin
      if (load) begin
        o       <= load_dat;
        o_ch    <= load_ch;
        o_valid <= 1'b1;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      if (scan_go) begin
        ch_q    <= '0;
        dwell_q <= DW_MAX;
      end else if (scan_load) begin
        if (more) ch_q <= tgt + SEL_W'(1);
        dwell_q <= '0;
      end else if (!expired) begin
        // Counts through stalls so a held sample never adds extra spacing.
        dwell_q <= dwell_q + DW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench: 8ch/DWELL=1 main instance, DWELL=3 spacing instance, 6ch out-of-range instance.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d = 32'h76543210;
  logic [2:0]  s;
  logic        mode, start, o_ready;
  logic [7:0]  mask = 8'hFF;

  logic [3:0]  o1, o3, o6;
  logic [2:0]  ch1, ch3, ch6;
  logic        v1, v3, v6, b1, b3, b6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_nx1 #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .start(start),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask),
`endif
    .o(o1), .o_ch(ch1), .o_valid(v1), .o_ready(o_ready), .busy(b1));

  mux_scan_nx1 #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL(3)) u3 (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .start(start),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask),
`endif
    .o(o3), .o_ch(ch3), .o_valid(v3), .o_ready(o_ready), .busy(b3));

  mux_scan_nx1 #(.CHANNELS(6), .WIDTH(4), .SEL_W(3), .DWELL(1)) u6 (
    .clk(clk), .rst_n(rst_n), .d(d[23:0]), .s(s), .mode(mode), .start(start),
`ifdef MUX_SCAN_MASK_EN
    .mask(mask[5:0]),
`endif
    .o(o6), .o_ch(ch6), .o_valid(v6), .o_ready(o_ready), .busy(b6));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with random inputs
    rst_n   = 1'b0;
    s       = 3'($urandom);
    mode    = 1'($urandom);
    start   = 1'($urandom);
    o_ready = 1'($urandom);
    tick();
    tick();
    chk("rst_o", 32'(o1), 0);
    chk("rst_ch", 32'(ch1), 0);
    chk("rst_valid", 32'(v1), 0);
    chk("rst_busy", 32'(b1), 0);

    // Direct mode sweep; u6 covers selects beyond its channel count
    rst_n = 1'b1; mode = 1'b0; start = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      tick();
      chk("dir_o", 32'(o1), k);
      chk("dir_ch", 32'(ch1), k);
      chk("dir_valid", 32'(v1), 1);
      chk("dir6_o", 32'(o6), (k < 6) ? k : 0);
      chk("dir6_ch", 32'(ch6), k);
      chk("dir6_valid", 32'(v6), 1);
    end

    // Direct hold under backpressure
    s = 3'd5;
    tick();
    o_ready = 1'b0; s = 3'd2;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_o", 32'(o1), 5);
      chk("hold_ch", 32'(ch1), 5);
    end
    o_ready = 1'b1;
    tick();
    chk("release_o", 32'(o1), 2);

    // Scan, DWELL=1: eight back-to-back loads
    do_reset();
    mode = 1'b1; start = 1'b1; o_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("scan_busy0", 32'(b1), 1);
    chk("scan_valid0", 32'(v1), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("scan_ch", 32'(ch1), k);
      chk("scan_o", 32'(o1), k);
      chk("scan_valid", 32'(v1), 1);
      chk("scan_busy", 32'(b1), 1);
    end
    tick();
    chk("scan_end_busy", 32'(b1), 0);
    chk("scan_end_valid", 32'(v1), 0);

    // Scan, DWELL=3: loads every third cycle
    do_reset();
    mode = 1'b1; start = 1'b1; o_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("dw3_valid", 32'(v3), (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 0) chk("dw3_ch", 32'(ch3), i / 3);
    end
    tick();
    chk("dw3_end_busy", 32'(b3), 0);

    // Backpressure at ch3 with start/mode toggles
    do_reset();
    mode = 1'b1; start = 1'b1; o_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_pre_ch", 32'(ch1), k);
    end
    o_ready = 1'b0; start = 1'b1; mode = 1'b0;
    tick();
    chk("bp_hold_o", 32'(o1), 3);
    chk("bp_hold_ch", 32'(ch1), 3);
    start = 1'b0; mode = 1'b1;
    tick();
    chk("bp_hold_ch", 32'(ch1), 3);
    start = 1'b1; mode = 1'b1;
    tick();
    chk("bp_hold_ch", 32'(ch1), 3);
    chk("bp_hold_valid", 32'(v1), 1);
    start = 1'b0; o_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tick();
      chk("bp_post_ch", 32'(ch1), k);
      chk("bp_post_o", 32'(o1), k);
    end
    tick();
    chk("bp_end_busy", 32'(b1), 0);

    // Reset mid-scan, then restart from ch0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_ch", 32'(ch1), 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_o", 32'(o1), 0);
    chk("mid_rst_ch", 32'(ch1), 0);
    chk("mid_rst_valid", 32'(v1), 0);
    chk("mid_rst_busy", 32'(b1), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_ch", 32'(ch1), 0);
    chk("restart_valid", 32'(v1), 1);
    chk("restart_busy", 32'(b1), 1);

`ifdef MUX_SCAN_MASK_EN
    do_reset();
    mask = 8'b1010_0101; mode = 1'b1; start = 1'b1; o_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("mask_ch", 32'(ch1), 0);
    tick(); chk("mask_ch", 32'(ch1), 0); chk("mask_valid", 32'(v1), 1);
    tick(); chk("mask_ch", 32'(ch1), 2);
    tick(); chk("mask_ch", 32'(ch1), 5);
    tick(); chk("mask_ch", 32'(ch1), 7); chk("mask_o", 32'(o1), 7);
    tick(); chk("mask_end_busy", 32'(b1), 0);
    mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_busy", 32'(b1), 0);
    mask = 8'b1010_0101; mode = 1'b0; s = 3'd1;
    tick();
    chk("mask_dir_o", 32'(o1), 0);
    chk("mask_dir_ch", 32'(ch1), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
